matrix_deconstruct: RTL and testbench

//  Reader-side counterpart of matrix_construct. On start, walks an mn_matrix instance

---
 rtl/matrix_deconstruct.sv | 169 ++++++++++++++++
 tb/tb_matrix_deconstruct.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_deconstruct.sv
// matrix_deconstruct: walks an mn_matrix over its read port and packs every entry row-major onto matrix_out.
// Optional feature macro DECONSTRUCT_TRANSPOSE_EN adds a transpose input so the block reads A' instead of A.
module matrix_deconstruct #(
   parameter int MAX_DIM = 128,
   parameter int DATA_W  = 32,
   parameter int DIM_W   = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [DIM_W-1:0]                  m_dim,
   input  logic [DIM_W-1:0]                  n_dim,
`ifdef DECONSTRUCT_TRANSPOSE_EN
   input  logic                              transpose,
`endif
   output logic                              read,
   output logic [DIM_W-1:0]                  m_addr,
   output logic [DIM_W-1:0]                  n_addr,
   input  logic [DATA_W-1:0]                 data_out,
   output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_out,
   output logic                              done,
   output logic                              q_Idle,
   output logic                              q_Read,
   output logic                              q_Drain,
   output logic                              q_Done,
   output logic                              transpose_o
);

   localparam int IDX_W = $clog2(MAX_DIM*MAX_DIM+1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t           state, state_n;
   logic [DIM_W-1:0] rows, rows_n, cols, cols_n;
   logic [DIM_W-1:0] m_addr_n, n_addr_n, m_sat, n_sat;
   logic [IDX_W-1:0] idx_p0, idx_p0_n, idx_p1;
   logic             vld_p1;
   logic             read_n, done_n, tr, tr_n, tr_sel, hold, hold_n, clr;

   function automatic logic [DIM_W-1:0] sat_dim(input logic [DIM_W-1:0] d);
      if (int'(d) > MAX_DIM) return DIM_W'(MAX_DIM);
      return d;
   endfunction

`ifdef DECONSTRUCT_TRANSPOSE_EN
   assign tr_sel = transpose;
`else
   assign tr_sel = 1'b0;
`endif

   assign m_sat = sat_dim(m_dim);
   assign n_sat = sat_dim(n_dim);

   always_comb begin
      state_n  = state;
      read_n   = 1'b0;
      done_n   = 1'b0;
      clr      = 1'b0;
      m_addr_n = m_addr;
      n_addr_n = n_addr;
      idx_p0_n = idx_p0;
      rows_n   = rows;
      cols_n   = cols;
      tr_n     = tr;
      hold_n   = hold;
      case (state)
         IDLE: begin
            if (start) begin
               clr      = 1'b1;
               tr_n     = tr_sel;
               rows_n   = tr_sel ? n_sat : m_sat;
               cols_n   = tr_sel ? m_sat : n_sat;
               m_addr_n = '0;
               n_addr_n = '0;
               idx_p0_n = '0;
               if (m_sat == '0 || n_sat == '0) begin
                  // Empty matrix: spend one extra cycle in DONE so latency stays R*C+2.
                  state_n = DONE;
                  hold_n  = 1'b1;
               end else begin
                  state_n = READ;
                  read_n  = 1'b1;
                  hold_n  = 1'b0;
               end
            end
         end
         READ: begin
            if (m_addr == rows - DIM_W'(1) && n_addr == cols - DIM_W'(1)) begin
               state_n = DRAIN;
            end else begin
               read_n   = 1'b1;
               idx_p0_n = idx_p0 + IDX_W'(1);
               if (n_addr == cols - DIM_W'(1)) begin
                  n_addr_n = '0;
                  m_addr_n = m_addr + DIM_W'(1);
               end else begin
                  n_addr_n = n_addr + DIM_W'(1);
               end
            end
         end
         DRAIN: state_n = DONE;
         DONE: begin
            if (hold) begin
               hold_n = 1'b0;
            end else begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Stage p0: state, issued address and its pack index
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         read        <= 1'b0;
         m_addr      <= '0;
         n_addr      <= '0;
         idx_p0      <= '0;
         rows        <= '0;
         cols        <= '0;
         tr          <= 1'b0;
         hold        <= 1'b0;
         done        <= 1'b0;
         transpose_o <= 1'b0;
         q_Idle      <= 1'b1;
         q_Read      <= 1'b0;
         q_Drain     <= 1'b0;
         q_Done      <= 1'b0;
      end else begin
         state       <= state_n;
         read        <= read_n;
         m_addr      <= m_addr_n;
         n_addr      <= n_addr_n;
         idx_p0      <= idx_p0_n;
         rows        <= rows_n;
         cols        <= cols_n;
         tr          <= tr_n;
         hold        <= hold_n;
         done        <= done_n;
         transpose_o <= tr_n & (state_n == READ || state_n == DRAIN);
         q_Idle      <= (state_n == IDLE);
         q_Read      <= (state_n == READ);
         q_Drain     <= (state_n == DRAIN);
         q_Done      <= (state_n == DONE);
      end
   end

   // Stage p1: index delayed to line up with data_out from the memory
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         idx_p1 <= '0;
      end else begin
         vld_p1 <= read;
         idx_p1 <= idx_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr)
         matrix_out <= '0;
      else if (vld_p1)
         matrix_out[int'(idx_p1)*DATA_W +: DATA_W] <= data_out;
   end

endmodule

// File: tb/tb_matrix_deconstruct.sv
// Self-checking bench for matrix_deconstruct: table vectors, random ops and reset/restart sequence.
`timescale 1ns/1ps
module tb_matrix_deconstruct;
   localparam int MAX_DIM = 4;
   localparam int DATA_W  = 32;
   localparam int DIM_W   = 8;
   localparam int TOT     = MAX_DIM*MAX_DIM*DATA_W;
   localparam int SEQ = 0, RND = 1, DEAD = 2;

   logic             clk = 1'b0;
   logic             reset, start;
   logic [DIM_W-1:0] m_dim, n_dim, m_addr, n_addr;
   logic             read, done, q_Idle, q_Read, q_Drain, q_Done, transpose_o;
   logic [DATA_W-1:0] data_out;
   logic [TOT-1:0]   matrix_out;
`ifdef DECONSTRUCT_TRANSPOSE_EN
   logic             transpose;
`endif

   logic [DATA_W-1:0] mem [MAX_DIM][MAX_DIM];
   int n_cmp = 0;
   int n_bad = 0;

   matrix_deconstruct #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
      .clk(clk), .reset(reset), .start(start), .m_dim(m_dim), .n_dim(n_dim),
`ifdef DECONSTRUCT_TRANSPOSE_EN
      .transpose(transpose),
`endif
      .read(read), .m_addr(m_addr), .n_addr(n_addr), .data_out(data_out),
      .matrix_out(matrix_out), .done(done), .q_Idle(q_Idle), .q_Read(q_Read),
      .q_Drain(q_Drain), .q_Done(q_Done), .transpose_o(transpose_o)
   );

   always #5 clk = ~clk;

   // mn_matrix read port: registered, one cycle of latency, optional transposed view
   function automatic logic [DATA_W-1:0] rd(input int r, input int c);
      if (r < MAX_DIM && c < MAX_DIM) return mem[r][c];
      return 32'hBAD0BAD0;
   endfunction

   always @(posedge clk)
      if (read)
         data_out <= transpose_o ? rd(int'(n_addr), int'(m_addr)) : rd(int'(m_addr), int'(n_addr));

   function automatic logic [TOT-1:0] expect_mat(input int R, input int C, input bit t);
      logic [TOT-1:0] e;
      e = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            e[(r*C+c)*DATA_W +: DATA_W] = t ? mem[c][r] : mem[r][c];
      return e;
   endfunction

   task automatic chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_m(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fill_mem(input int mode, input int ns);
      for (int r = 0; r < MAX_DIM; r++)
         for (int c = 0; c < MAX_DIM; c++)
            mem[r][c] = $urandom;
      if (mode == SEQ)
         for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < ns; c++)
               mem[r][c] = DATA_W'(r*ns + c + 1);
      if (mode == DEAD) mem[0][0] = 32'hDEADBEEF;
   endtask

   task automatic run_op(input int m, input int n, input bit t_in, input bit spam,
                         input int lat_exp, input string tag);
      int ms, ns, R, C, lat, reads, aerr, got;
      bit t;
      logic [TOT-1:0] exp;
      t = t_in;
`ifndef DECONSTRUCT_TRANSPOSE_EN
      t = 1'b0;
`endif
      ms = (m > MAX_DIM) ? MAX_DIM : m;
      ns = (n > MAX_DIM) ? MAX_DIM : n;
      R = t ? ns : ms;
      C = t ? ms : ns;
      exp = (R == 0 || C == 0) ? '0 : expect_mat(R, C, t);
      if (lat_exp < 0) lat_exp = R*C + 2;

      @(negedge clk);
      m_dim = DIM_W'(m);
      n_dim = DIM_W'(n);
`ifdef DECONSTRUCT_TRANSPOSE_EN
      transpose = t;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // later dim changes must not matter
      m_dim = DIM_W'($urandom);
      n_dim = DIM_W'($urandom);
`ifdef DECONSTRUCT_TRANSPOSE_EN
      transpose = 1'($urandom);
`endif
      lat = 0; reads = 0; aerr = 0; got = 0;
      for (int k = 0; k < 300; k++) begin
         if (read) begin
            if (C == 0) aerr++;
            else if (int'(m_addr) != reads / C || int'(n_addr) != reads % C) aerr++;
            reads++;
         end
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
         lat++;
         start = spam & read;
      end
      start = 1'b0;
      chk_i({tag, ".done_seen"}, got, 1);
      chk_i({tag, ".latency"}, lat, lat_exp);
      chk_i({tag, ".read_cycles"}, reads, R*C);
      chk_i({tag, ".addr_errors"}, aerr, 0);
      chk_m({tag, ".matrix"}, matrix_out, exp);
      @(negedge clk);
      chk_i({tag, ".done_pulse"}, int'({done, q_Idle}), 1);
      chk_m({tag, ".hold"}, matrix_out, exp);
   endtask

   typedef struct {
      int m;
      int n;
      bit t;
      bit spam;
      int fill;
      int lat;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{3, 2, 1'b0, 1'b0, SEQ,  8};
      tbl[1] = '{3, 2, 1'b1, 1'b0, SEQ,  8};
      tbl[2] = '{0, 5, 1'b0, 1'b0, SEQ,  2};
      tbl[3] = '{1, 1, 1'b0, 1'b0, DEAD, 3};
      tbl[4] = '{3, 2, 1'b0, 1'b1, SEQ,  8};
      tbl[5] = '{4, 4, 1'b0, 1'b0, RND, 18};
      tbl[6] = '{7, 2, 1'b0, 1'b0, RND, 10};
      tbl[7] = '{2, 9, 1'b1, 1'b1, RND, 10};
      tbl[8] = '{3, 0, 1'b0, 1'b0, RND,  2};
      tbl[9] = '{1, 4, 1'b1, 1'b0, RND,  6};

      reset = 1'b1; start = 1'b0; m_dim = '0; n_dim = '0;
`ifdef DECONSTRUCT_TRANSPOSE_EN
      transpose = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk_i("reset.ctrl", int'({read, done, q_Idle, q_Read, q_Drain, q_Done, transpose_o, m_addr, n_addr}),
            1 << 20);
      chk_m("reset.matrix", matrix_out, '0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         fill_mem(tbl[i].fill, (tbl[i].n > MAX_DIM) ? MAX_DIM : tbl[i].n);
         run_op(tbl[i].m, tbl[i].n, tbl[i].t, tbl[i].spam, tbl[i].lat, $sformatf("vec%0d", i));
         if (i == 0 || i == 4)
            chk_i($sformatf("vec%0d.low", i), int'(matrix_out[191:0] == {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}), 1);
         if (i == 3)
            chk_i("vec3.word", int'(matrix_out[31:0]), int'(32'hDEADBEEF));
`ifdef DECONSTRUCT_TRANSPOSE_EN
         if (i == 1)
            chk_i("vec1.low_t", int'(matrix_out[191:0] == {32'd6, 32'd4, 32'd2, 32'd5, 32'd3, 32'd1}), 1);
`endif
      end

      // reset in the third READ cycle, then restart
      fill_mem(SEQ, 2);
      @(negedge clk);
      m_dim = 8'd3; n_dim = 8'd2; start = 1'b1;
`ifdef DECONSTRUCT_TRANSPOSE_EN
      transpose = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_i("rst.in_read", int'({q_Read, read}), 3);
      chk_i("rst.partial", int'(matrix_out[31:0]), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_i("rst.ctrl", int'({read, done, q_Idle, q_Read, q_Drain, q_Done}), 6'b001000);
      chk_m("rst.matrix", matrix_out, '0);
      begin
         int dones;
         dones = 0;
         for (int k = 0; k < 12; k++) begin
            if (done) dones++;
            @(negedge clk);
         end
         chk_i("rst.no_done", dones, 0);
      end
      run_op(3, 2, 1'b0, 1'b0, 8, "restart");
      chk_i("restart.low", int'(matrix_out[191:0] == {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}), 1);

      for (int i = 0; i < 15; i++) begin
         int m, n;
         m = $urandom_range(0, 6);
         n = $urandom_range(0, 6);
         fill_mem(RND, 0);
         run_op(m, n, 1'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
